// File: rtl/encoder_pkg.sv
// Shared encoder types: ping-pong bank states and bank identifiers.
package encoder_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY    = 2'd0,
    BUF_FILLING  = 2'd1,
    BUF_FULL     = 2'd2,
    BUF_DRAINING = 2'd3
  } buf_state_e;

  localparam logic PP_PING = 1'b0;
  localparam logic PP_PONG = 1'b1;

  function automatic logic buf_writable(buf_state_e s);
    return (s == BUF_EMPTY) || (s == BUF_FILLING);
  endfunction

  function automatic logic buf_readable(buf_state_e s);
    return (s == BUF_FULL) || (s == BUF_DRAINING);
  endfunction

endpackage

// File: rtl/pingpong_ctrl_delay.sv
// LATENCY-stage shift register with synchronous flush; aligns read-issue tags
// with the bank read pipeline.
module pp_delay_line #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [LATENCY];

  // NOTE: every stage is reset; these are a few control flops, not a data RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[LATENCY-1];

endmodule

// File: rtl/pingpong_ctrl.sv
// Ping-pong bank sequencer: fills one bank while the other drains, frames in
// write order, with read valid/select/last aligned to the bank read latency.
module pingpong_ctrl
  import encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int FRAME_LEN  = 1024,
  parameter int BANK_NUM   = 8,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [BANK_NUM-1:0]   ping_wen_o,
  output logic [BANK_NUM-1:0]   pong_wen_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  input  logic                  rd_req_i,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  output logic                  rd_valid_o,
  output logic                  rd_sel_o,
  output logic                  rd_last_o,
  output logic [1:0]            full_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  buf_state_e [1:0]      state_q, state_d;
  logic                  wbuf_q, rbuf_q;
  logic [ADDR_WIDTH-1:0] wcnt_q, rcnt_q, raddr_q;
  logic [1:0]            full_cnt_q;
  logic                  wr_fire, rd_issue, fill_done, drain_done;
  logic [2:0]            dly_q;

  // Write and read target different banks by construction: a bank is either
  // writable or readable, never both.
  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    wr_ready_o = buf_writable(state_q[wbuf_q]);
    wr_fire    = wr_valid_i & wr_ready_o;
    rd_issue   = rd_req_i & buf_readable(state_q[rbuf_q]);
    fill_done  = wr_fire && (wcnt_q == LAST_ADDR);
    drain_done = rd_issue && (rcnt_q == LAST_ADDR);
    if (wr_fire)  state_d[wbuf_q] = fill_done  ? BUF_FULL  : BUF_FILLING;
    if (rd_issue) state_d[rbuf_q] = drain_done ? BUF_EMPTY : BUF_DRAINING;
  end

  assign ping_wen_o = {BANK_NUM{wr_fire && (wbuf_q == PP_PING)}};
  assign pong_wen_o = {BANK_NUM{wr_fire && (wbuf_q == PP_PONG)}};
  assign waddr_o    = wcnt_q;
  assign raddr_o    = rd_issue ? rcnt_q : raddr_q;
  assign full_cnt_o = full_cnt_q;

  // NOTE: state uses <= so every flop samples pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= {BUF_EMPTY, BUF_EMPTY};
      wbuf_q     <= PP_PING;
      rbuf_q     <= PP_PING;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      raddr_q    <= '0;
      full_cnt_q <= '0;
    end else if (clear_i) begin
      state_q    <= {BUF_EMPTY, BUF_EMPTY};
      wbuf_q     <= PP_PING;
      rbuf_q     <= PP_PING;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      raddr_q    <= '0;
      full_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_done) begin
        wcnt_q <= '0;
        wbuf_q <= ~wbuf_q;
      end else if (wr_fire) begin
        wcnt_q <= wcnt_q + ADDR_WIDTH'(1);
      end
      if (rd_issue) raddr_q <= rcnt_q;
      if (drain_done) begin
        rcnt_q <= '0;
        rbuf_q <= ~rbuf_q;
      end else if (rd_issue) begin
        rcnt_q <= rcnt_q + ADDR_WIDTH'(1);
      end
      full_cnt_q <= full_cnt_q + 2'(fill_done) - 2'(drain_done);
    end
  end

  pp_delay_line #(.WIDTH(3), .LATENCY(LATENCY)) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear_i),
    .d     ({rd_issue, rbuf_q, drain_done}),
    .q     (dly_q)
  );

  assign {rd_valid_o, rd_sel_o, rd_last_o} = dly_q;

endmodule

// File: doc/pingpong_ctrl.md
# pingpong_ctrl

Sequencing controller for the encoder's ping-pong buffer pair, two `ram_bank` instances named PING and PONG. A producer streams fixed-length frames into one bank while a consumer drains the previously completed frame from the other. The block generates write enables, write and read addresses, and the read-data select/valid alignment for the bank's `LATENCY`-cycle read pipeline. It sits between the upstream encoder stage and the downstream consumer.

## Interface
- `ADDR_WIDTH`, 10, bank address width.
- `FRAME_LEN`, 1024, words per frame; legal range 2..2^ADDR_WIDTH.
- `BANK_NUM`, 8, sub-banks per `ram_bank`; write enables are replicated across all of them.
- `LATENCY`, 1, bank read latency in cycles; must be ≥1.
- `clk` in 1: single clock; all state is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear_i` in 1: synchronous soft clear; returns the block to its reset state.
- `wr_valid_i` in 1: producer has a word on the datapath this cycle.
- `wr_ready_o` out 1: controller accepts the word this cycle.
- `ping_wen_o` out BANK_NUM: write enables for PING.
- `pong_wen_o` out BANK_NUM: write enables for PONG.
- `waddr_o` out ADDR_WIDTH: write address, shared by both banks.
- `rd_req_i` in 1: consumer permits a read issue this cycle and guarantees room for ≤LATENCY words in flight.
- `raddr_o` out ADDR_WIDTH: read address, shared by both banks.
- `rd_valid_o` out 1: bank `rdata` carries a valid word this cycle.
- `rd_sel_o` out 1: rdata mux select (0=PING, 1=PONG), aligned with `rd_valid_o`.
- `rd_last_o` out 1: final word of the frame, aligned with `rd_valid_o`.
- `full_cnt_o` out 2: number of banks holding a complete, not-yet-drained frame (0..2).

## Operation
- Each bank has a state in `{EMPTY, FILLING, FULL, DRAINING}`. Pointers: `wbuf` (bank being written), `rbuf` (bank being read), `wcnt`, `rcnt`.
- Write path:
  - `wr_ready_o = state[wbuf] ∈ {EMPTY, FILLING}`.
  - On a write fire (`wr_valid_i & wr_ready_o`), the selected bank's `*_wen_o` = all ones, `waddr_o = wcnt`, and EMPTY→FILLING.
  - On a fire with `wcnt == FRAME_LEN-1`: bank→FULL, `wcnt` reset to 0, `wbuf` toggles.
  - The write outputs are combinational from the current state and `wr_valid_i`.
- Read path:
  - A read is issued when `rd_req_i` is high and `state[rbuf] ∈ {FULL, DRAINING}`. On issue, `raddr_o = rcnt` and FULL→DRAINING.
  - On the issue with `rcnt == FRAME_LEN-1`: bank→EMPTY immediately, `rcnt` reset to 0, `rbuf` toggles.
  - `raddr_o` holds its last value when no read is issued.
- Read-issue alignment: `{issue, rbuf, last}` is delayed LATENCY cycles to produce `rd_valid_o`, `rd_sel_o` and `rd_last_o`.
- Frames are delivered in write order (a 2-deep FIFO of banks); `rbuf` always follows `wbuf`.
- A bank is never written and read in the same cycle. This is guaranteed by the state encoding and is required because `ram_bank` suppresses reads on written sub-banks.
- Freeing a bank at last-issue is safe: the issued word is already captured in the bank's first read register, so a write to address 0 on the next cycle cannot corrupt it.
- Simultaneous events: a fill-complete on one bank and a drain-complete on the other in the same cycle both take effect, and `full_cnt_o` nets to unchanged.
- With both banks FULL, `wr_ready_o` = 0 until the first read issue moves `rbuf` to DRAINING. It then stays 0 until that bank reaches EMPTY.
- `clear_i` and reset mid-frame both do the following:
  - both banks→EMPTY; pointers and counters→0;
  - the delay line is flushed, so in-flight `rd_valid_o` is cancelled from the next cycle;
  - any partial frame is discarded.

## Timing
- Reset values: `wr_ready_o`=1; every other output is 0, including `waddr_o`, `raddr_o`, `rd_sel_o` and `full_cnt_o`.
- Write: the address and enable appear in the same cycle as the fire. The bank becomes readable (FULL) in the cycle after the last write.
- Read: the issue in cycle t produces `rd_valid_o` in cycle t+LATENCY.
- Throughput: 1 word/cycle on each port; no bubbles between frames when the consumer keeps up.
- `full_cnt_o` is registered: it increments on the cycle after a fill-complete and decrements on the cycle after a last-issue.

## Structure
- Shared package `encoder_pkg`: `buf_state_e` enum and the `PP_PING`/`PP_PONG` constants.
- One sub-module, `pp_delay_line`: a width-parameterised LATENCY-stage shift register with synchronous flush, used for the valid/sel/last alignment.

## Test plan
- Write 1024 words with `rd_req_i`=0:
  - `ping_wen_o`=8'hFF at addresses 0..1023;
  - `full_cnt_o`=1 one cycle after the last write;
  - `wr_ready_o` stays 1, and the next write goes to PONG address 0.
- Fill PING and PONG with `rd_req_i`=0 → `wr_ready_o`=0 and `full_cnt_o`=2. Pulse `rd_req_i` once → `raddr_o`=0, then `rd_valid_o` and `rd_sel_o`=0 LATENCY cycles later.
- Streaming with LATENCY=3, producer and consumer always active → continuous `rd_valid_o`; `rd_last_o` every 1024th valid word; `rd_sel_o` alternates 0/1 per frame.
- Same cycle: PONG write address 1023 and PING read issue address 1023 → PING EMPTY, PONG FULL, `full_cnt_o` unchanged, and the next write goes to PING address 0.
- Deassert `rst_n` (or assert `clear_i`) mid-read with 2 words in flight → no `rd_valid_o` afterwards; all outputs return to their reset values; `wr_ready_o`=1.
- FRAME_LEN=2 boundary → states cycle EMPTY→FILLING→FULL→DRAINING→EMPTY with correct address wrap.
